// File: rtl/spi_xfer_sched_if.sv
// Bundle of requester-side and spi_master-side signals of the SPI transfer scheduler.
// The master modport is the scheduler's view; slave is the view of its environment.
interface spi_xfer_sched_if #(
    parameter int DWIDTH = 8,
    parameter int NREQ   = 2,
    parameter int LENW   = 4
);
    logic [NREQ-1:0]        i_req;
    logic [NREQ*LENW-1:0]   i_req_len;
    logic [NREQ-1:0]        i_req_cpol;
    logic [NREQ-1:0]        i_req_cpha;
    logic [NREQ*DWIDTH-1:0] i_tx_data;
    logic [NREQ-1:0]        o_gnt;
    logic                   o_tx_rd;
    logic [DWIDTH-1:0]      o_rx_byte;
    logic                   o_rx_vld;
    logic                   o_done;
    logic                   o_err;
    logic                   o_busy;
    logic [DWIDTH-1:0]      o_m_tx_byte;
    logic                   o_m_tx_de;
    logic [DWIDTH-1:0]      i_m_rx_byte;
    logic                   i_m_rx_de;
    logic                   o_m_cpol;
    logic                   o_m_cpha;

    modport master (
        input  i_req, i_req_len, i_req_cpol, i_req_cpha, i_tx_data,
        input  i_m_rx_byte, i_m_rx_de,
        output o_gnt, o_tx_rd, o_rx_byte, o_rx_vld, o_done, o_err, o_busy,
        output o_m_tx_byte, o_m_tx_de, o_m_cpol, o_m_cpha
    );

    modport slave (
        output i_req, i_req_len, i_req_cpol, i_req_cpha, i_tx_data,
        output i_m_rx_byte, i_m_rx_de,
        input  o_gnt, o_tx_rd, o_rx_byte, o_rx_vld, o_done, o_err, o_busy,
        input  o_m_tx_byte, o_m_tx_de, o_m_cpol, o_m_cpha
    );
endinterface

// File: rtl/spi_xfer_sched.sv
// Round-robin scheduler of multi-byte SPI bursts from NREQ requesters onto one spi_master,
// with per-burst clock mode, byte pacing, RX return and response timeout.
module spi_xfer_sched #(
    parameter int DWIDTH    = 8,
    parameter int NREQ      = 2,
    parameter int LENW      = 4,
    parameter int SETUP_CYC = 4,
    parameter int GAP_CYC   = 2,
    parameter int TO_CYC    = 1024
) (
    input  logic             i_clk,
    input  logic             rst_n,
    spi_xfer_sched_if.master bus
);
    localparam int IDXW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX0      = (TO_CYC > SETUP_CYC) ? TO_CYC : SETUP_CYC;
    localparam int CMAX       = (CMAX0 > GAP_CYC) ? CMAX0 : GAP_CYC;
    localparam int CNTW       = $clog2(CMAX + 1);
    // The SEND cycle is the last idle cycle of the setup window, so SETUP itself runs SETUP_CYC-1 cycles.
    localparam int SETUP_LAST = (SETUP_CYC >= 2) ? SETUP_CYC - 2 : 0;
    localparam int GAP_LAST   = (GAP_CYC >= 1) ? GAP_CYC - 1 : 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SEND,
        ST_WAIT,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [IDXW-1:0]     gidx_q, gidx_d;
    logic [IDXW-1:0]     ptr_q, ptr_d;
    logic [LENW-1:0]     rem_q, rem_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic [DWIDTH-1:0]   tx_byte_q, tx_byte_d;
    logic                tx_de_q, tx_de_d;
    logic                tx_rd_q, tx_rd_d;
    logic [DWIDTH-1:0]   rx_byte_q, rx_byte_d;
    logic                rx_vld_q, rx_vld_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    logic [LENW-1:0]     len_arr [NREQ];
    logic [DWIDTH-1:0]   tx_arr  [NREQ];
    logic                arb_found;
    logic [IDXW-1:0]     arb_idx;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign len_arr[gi] = bus.i_req_len[gi*LENW +: LENW];
        assign tx_arr[gi]  = bus.i_tx_data[gi*DWIDTH +: DWIDTH];
    end

    // Walk the ring backwards from ptr so the lowest offset with a request wins last.
    always_comb begin
        int cand;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = int'(ptr_q) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (bus.i_req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = IDXW'(cand);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        tx_byte_d = tx_byte_q;
        rx_byte_d = rx_byte_q;
        tx_de_d   = 1'b0;
        tx_rd_d   = 1'b0;
        rx_vld_d  = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    gnt_d  = NREQ'(1) << arb_idx;
                    gidx_d = arb_idx;
                    rem_d  = len_arr[arb_idx];
                    cpol_d = bus.i_req_cpol[arb_idx];
                    cpha_d = bus.i_req_cpha[arb_idx];
                    cnt_d  = '0;
                    if (len_arr[arb_idx] == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (SETUP_CYC <= 1) begin
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNTW'(SETUP_LAST)) begin
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SEND: begin
                tx_byte_d = tx_arr[gidx_q];
                tx_de_d   = 1'b1;
                tx_rd_d   = 1'b1;
                cnt_d     = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.i_m_rx_de) begin
                    rx_byte_d = bus.i_m_rx_byte;
                    rx_vld_d  = 1'b1;
                    rem_d     = rem_q - LENW'(1);
                    cnt_d     = '0;
                    if (rem_q == LENW'(1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (GAP_CYC == 0) begin
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else if (cnt_q == CNTW'(TO_CYC - 1)) begin
                    // No response from the master: abort and drop what is left of the burst.
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == CNTW'(GAP_LAST)) begin
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                gnt_d   = '0;
                ptr_d   = (gidx_q == IDXW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gidx_q    <= '0;
            ptr_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            tx_byte_q <= '0;
            tx_de_q   <= 1'b0;
            tx_rd_q   <= 1'b0;
            rx_byte_q <= '0;
            rx_vld_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            tx_byte_q <= tx_byte_d;
            tx_de_q   <= tx_de_d;
            tx_rd_q   <= tx_rd_d;
            rx_byte_q <= rx_byte_d;
            rx_vld_q  <= rx_vld_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.o_gnt       = gnt_q;
    assign bus.o_tx_rd     = tx_rd_q;
    assign bus.o_rx_byte   = rx_byte_q;
    assign bus.o_rx_vld    = rx_vld_q;
    assign bus.o_done      = done_q;
    assign bus.o_err       = err_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_m_tx_byte = tx_byte_q;
    assign bus.o_m_tx_de   = tx_de_q;
    assign bus.o_m_cpol    = cpol_q;
    assign bus.o_m_cpha    = cpha_q;
endmodule

// File: tb/tb_spi_xfer_sched.sv
// Directed bench for spi_xfer_sched: table of single bursts plus hand-written corner sequences,
// with an spi_master stand-in that answers each byte ECHO cycles later with byte^A5.
module tb_spi_xfer_sched;
    localparam int DW = 8, NR = 2, LW = 4, SETUP = 4, GAP = 2, TO = 1024, ECHO = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_xfer_sched_if #(.DWIDTH(DW), .NREQ(NR), .LENW(LW)) bus ();

    spi_xfer_sched #(
        .DWIDTH(DW), .NREQ(NR), .LENW(LW),
        .SETUP_CYC(SETUP), .GAP_CYC(GAP), .TO_CYC(TO)
    ) dut (
        .i_clk(clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    logic [NR-1:0] req = '0, cpol = '0, cpha = '0;
    logic [LW-1:0] len [NR];
    logic [DW-1:0] tx_base [NR];
    int            rd_cnt [NR];
    logic          force_rx_de = 1'b0, model_en = 1'b0, model_rx_de = 1'b0;
    logic [DW-1:0] model_rx_byte = '0;

    for (genvar gi = 0; gi < NR; gi++) begin : g_drv
        assign bus.i_req_len[gi*LW +: LW] = len[gi];
        assign bus.i_tx_data[gi*DW +: DW] = tx_base[gi] + DW'(rd_cnt[gi]);
    end
    assign bus.i_req       = req;
    assign bus.i_req_cpol  = cpol;
    assign bus.i_req_cpha  = cpha;
    assign bus.i_m_rx_de   = model_rx_de | force_rx_de;
    assign bus.i_m_rx_byte = model_rx_byte;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_txde = 0, n_txrd = 0, n_rxvld = 0, n_done = 0, n_err = 0;
    int txde_cyc = 0, done_cyc = 0, pend = 0;
    logic [DW-1:0] pend_byte = '0;
    logic [DW-1:0] rx_q [$];
    logic [DW-1:0] tx_q [$];

    // Master stand-in and event monitor, both evaluated mid-cycle.
    always @(negedge clk) begin
        model_rx_de = 1'b0;
        if (!rst_n) begin
            pend = 0;
        end else if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                model_rx_de   = 1'b1;
                model_rx_byte = pend_byte ^ 8'hA5;
            end
        end
        if (bus.o_m_tx_de && model_en && rst_n) begin
            pend      = ECHO;
            pend_byte = bus.o_m_tx_byte;
        end
        if (bus.o_tx_rd) begin
            for (int k = 0; k < NR; k++) if (bus.o_gnt[k]) rd_cnt[k] = rd_cnt[k] + 1;
            n_txrd = n_txrd + 1;
        end
        if (bus.o_m_tx_de) begin
            n_txde   = n_txde + 1;
            txde_cyc = cyc;
            tx_q.push_back(bus.o_m_tx_byte);
        end
        if (bus.o_rx_vld) begin
            n_rxvld = n_rxvld + 1;
            rx_q.push_back(bus.o_rx_byte);
        end
        if (bus.o_done) begin
            n_done   = n_done + 1;
            done_cyc = cyc;
        end
        if (bus.o_err) n_err = n_err + 1;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return {bus.o_gnt, bus.o_tx_rd, bus.o_rx_byte, bus.o_rx_vld, bus.o_done, bus.o_err,
                bus.o_busy, bus.o_m_tx_byte, bus.o_m_tx_de, bus.o_m_cpol, bus.o_m_cpha};
    endfunction

    task automatic wait_gnt(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            if (bus.o_gnt != '0) ok = 1'b1;
        end
        if (!ok) chk({name, "_gnt_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            tick();
            if (!bus.o_busy) ok = 1'b1;
        end
        if (!ok) chk({name, "_idle_timeout"}, 0, 1);
    endtask

    typedef struct {
        logic [NR-1:0] req;
        logic [LW-1:0] len;
        logic          cpol, cpha, echo;
        logic [NR-1:0] exp_gnt;
        int            exp_tx, exp_rx;
        logic          exp_err;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int s_tx, s_rd, s_rx, s_done, s_err, rd0, gk, cpol_cyc, t_cyc;
        logic [NR-1:0] g;
        logic gnt_bad, bad;
        logic [NR-1:0] gq [$];
        int gaps [$];
        int zcnt;
        logic seen;

        for (int k = 0; k < NR; k++) begin
            len[k] = '0;
            tx_base[k] = '0;
            rd_cnt[k] = 0;
        end

        //            req    len cpol cpha echo gnt  tx  rx err
        tbl[0] = '{2'b01, 4'd3,  0, 0, 1, 2'b01, 3,  3,  0};
        tbl[1] = '{2'b10, 4'd2,  1, 0, 1, 2'b10, 2,  2,  0};
        tbl[2] = '{2'b01, 4'd0,  0, 1, 1, 2'b01, 0,  0,  0};
        tbl[3] = '{2'b11, 4'd1,  1, 1, 1, 2'b10, 1,  1,  0};
        tbl[4] = '{2'b01, 4'd15, 1, 1, 1, 2'b01, 15, 15, 0};
        tbl[5] = '{2'b10, 4'd2,  0, 0, 0, 2'b10, 1,  0,  1};

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", all_outs(), 0);
        rst_n = 1'b1;
        tick();
        chk("idle_after_reset", all_outs(), 0);

        for (int r = 0; r < 6; r++) begin
            s_tx = n_txde; s_rd = n_txrd; s_rx = n_rxvld; s_done = n_done; s_err = n_err;
            rx_q.delete(); tx_q.delete();
            model_en = tbl[r].echo;
            for (int k = 0; k < NR; k++) begin
                len[k]     = tbl[r].len;
                cpol[k]    = tbl[r].cpol;
                cpha[k]    = tbl[r].cpha;
                tx_base[k] = DW'(8'h20 * r + 8'h80 * k);
            end
            req = tbl[r].req;
            wait_gnt($sformatf("row%0d", r));
            g  = bus.o_gnt;
            gk = g[1] ? 1 : 0;
            rd0 = rd_cnt[gk];
            req = '0;
            gnt_bad = 1'b0;
            for (int i = 0; i < 3000 && bus.o_busy; i++) begin
                if (bus.o_gnt !== g) gnt_bad = 1'b1;
                tick();
            end
            chk("tbl_busy_end", bus.o_busy, 0);
            chk("tbl_gnt", g, tbl[r].exp_gnt);
            chk("tbl_gnt_stable", gnt_bad, 0);
            chk("tbl_tx_de", n_txde - s_tx, tbl[r].exp_tx);
            chk("tbl_tx_rd", n_txrd - s_rd, tbl[r].exp_tx);
            chk("tbl_rx_vld", n_rxvld - s_rx, tbl[r].exp_rx);
            chk("tbl_done", n_done - s_done, 1);
            chk("tbl_err", n_err - s_err, tbl[r].exp_err);
            chk("tbl_mode", {bus.o_m_cpol, bus.o_m_cpha}, {tbl[r].cpol, tbl[r].cpha});
            bad = 1'b0;
            for (int j = 0; j < tbl[r].exp_tx; j++) begin
                if (j >= tx_q.size() || tx_q[j] !== DW'(tx_base[gk] + DW'(rd0 + j))) bad = 1'b1;
            end
            for (int j = 0; j < tbl[r].exp_rx; j++) begin
                if (j >= rx_q.size() || rx_q[j] !== (DW'(tx_base[gk] + DW'(rd0 + j)) ^ 8'hA5)) bad = 1'b1;
            end
            chk("tbl_bytes", bad, 0);
            if (tbl[r].exp_err) chk("timeout_latency", done_cyc - txde_cyc, TO);
            $display("row %0d req=%b len=%0d gnt=%b tx=%0d rx=%0d err=%0d", r, tbl[r].req,
                     tbl[r].len, g, n_txde - s_tx, n_rxvld - s_rx, n_err - s_err);
            tick();
        end

        // Round-robin from reset with both requesters high
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_en = 1'b1;
        for (int k = 0; k < NR; k++) begin
            len[k] = 4'd1; cpol[k] = 1'b0; cpha[k] = 1'b0;
        end
        req = 2'b11;
        gq.delete(); gaps.delete();
        zcnt = 0; seen = 1'b0; g = '0;
        for (int i = 0; i < 400 && gq.size() < 3; i++) begin
            tick();
            if (bus.o_gnt != '0 && bus.o_gnt != g) begin
                gq.push_back(bus.o_gnt);
                if (seen) gaps.push_back(zcnt);
                seen = 1'b1;
                zcnt = 0;
            end else if (bus.o_gnt == '0 && seen) begin
                zcnt = zcnt + 1;
            end
            g = bus.o_gnt;
        end
        req = '0;
        chk("rr_grants", gq.size(), 3);
        if (gq.size() == 3) begin
            chk("rr_gnt0", gq[0], 2'b01);
            chk("rr_gnt1", gq[1], 2'b10);
            chk("rr_gnt2", gq[2], 2'b01);
            chk("rr_gap0", gaps[0], 1);
            chk("rr_gap1", gaps[1], 1);
        end
        $display("round-robin grants=%0d", gq.size());
        wait_idle("rr");
        tick();

        // Mode set up SETUP cycles before the first byte
        cpol[1] = 1'b1; cpha[1] = 1'b1; len[1] = 4'd1;
        req = 2'b10;
        cpol_cyc = -1; t_cyc = -1;
        for (int i = 0; i < 100 && t_cyc < 0; i++) begin
            tick();
            if (bus.o_gnt != '0) req = '0;
            if (cpol_cyc < 0 && bus.o_m_cpol && bus.o_m_cpha) cpol_cyc = cyc;
            if (bus.o_m_tx_de) t_cyc = cyc;
        end
        chk("setup_seen", (cpol_cyc >= 0 && t_cyc >= 0), 1);
        chk("setup_lead", t_cyc - cpol_cyc, SETUP);
        $display("mode setup lead=%0d cycles", t_cyc - cpol_cyc);
        wait_idle("setup");
        tick();

        // Zero-length burst
        s_tx = n_txde; s_done = n_done;
        len[0] = 4'd0;
        req = 2'b01;
        wait_gnt("len0");
        req = '0;
        chk("len0_done_with_gnt", {bus.o_done, bus.o_gnt}, {1'b1, 2'b01});
        tick();
        chk("len0_released", {bus.o_gnt, bus.o_busy}, 0);
        chk("len0_no_tx", n_txde - s_tx, 0);
        chk("len0_done_cnt", n_done - s_done, 1);
        $display("len0 burst done=%0d", n_done - s_done);

        // Spurious rx_de while idle
        s_rx = n_rxvld;
        force_rx_de = 1'b1;
        tick();
        force_rx_de = 1'b0;
        tick();
        chk("idle_rx_ignored", n_rxvld - s_rx, 0);
        $display("idle rx_de rx_vld=%0d", n_rxvld - s_rx);

        // Reset in the middle of WAIT
        len[0] = 4'd2;
        req = 2'b01;
        t_cyc = -1;
        for (int i = 0; i < 100 && t_cyc < 0; i++) begin
            tick();
            if (bus.o_m_tx_de) t_cyc = cyc;
        end
        chk("rst_burst_started", t_cyc >= 0, 1);
        req = '0;
        repeat (3) tick();
        s_done = n_done; s_rx = n_rxvld;
        rst_n = 1'b0;
        tick();
        chk("rst_wait_outputs", all_outs(), 0);
        rst_n = 1'b1;
        repeat (20) tick();
        chk("rst_no_done", n_done - s_done, 0);
        chk("rst_no_rx", n_rxvld - s_rx, 0);
        len[1] = 4'd1;
        req = 2'b10;
        wait_gnt("post_rst");
        chk("post_rst_gnt", bus.o_gnt, 2'b10);
        req = '0;
        wait_idle("post_rst");
        chk("post_rst_done", n_done - s_done, 1);
        chk("post_rst_rx", n_rxvld - s_rx, 1);
        $display("post-reset burst done=%0d rx=%0d", n_done - s_done, n_rxvld - s_rx);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
